// File: rtl/branch_predictor.sv
// Bimodal 2-bit saturating-counter direction predictor with update-side stats.
// Optional gshare indexing when GSHARE_EN is defined (adds GHR, pred_ghr, upd_ghr).
module branch_predictor #(
  parameter int IDX_BITS   = 6,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pred_req,
  input  logic [31:0]           pred_pc,
  output logic                  pred_valid,
  output logic                  pred_taken,
`ifdef GSHARE_EN
  output logic [IDX_BITS-1:0]   pred_ghr,
  input  logic [IDX_BITS-1:0]   upd_ghr,
`endif
  input  logic                  upd_valid,
  input  logic [31:0]           upd_pc,
  input  logic                  upd_taken,
  input  logic                  upd_pred_taken,
  output logic                  mispredict,
  output logic [STAT_WIDTH-1:0] branch_count,
  output logic [STAT_WIDTH-1:0] mispredict_count
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          ctr_q [ENTRIES];
  logic [IDX_BITS-1:0] pred_idx;
  logic [IDX_BITS-1:0] upd_idx;
  logic [1:0]          upd_old;
  logic [1:0]          upd_new;
  logic                miss;

`ifdef GSHARE_EN
  logic [IDX_BITS-1:0] ghr_q;

  assign pred_idx = pred_pc[IDX_BITS+1:2] ^ ghr_q;
  assign upd_idx  = upd_pc[IDX_BITS+1:2] ^ upd_ghr;

  // Lookup captures the pre-shift history it was indexed with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ghr_q    <= '0;
      pred_ghr <= '0;
    end else begin
      if (pred_req)
        pred_ghr <= ghr_q;
      if (upd_valid)
        ghr_q <= {ghr_q[IDX_BITS-2:0], upd_taken};
    end
  end
`else
  assign pred_idx = pred_pc[IDX_BITS+1:2];
  assign upd_idx  = upd_pc[IDX_BITS+1:2];
`endif

  logic unused;
  assign unused = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0],
                    upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

  assign upd_old = ctr_q[upd_idx];
  assign miss    = upd_taken ^ upd_pred_taken;

  always_comb begin
    upd_new = upd_old;
    unique case (1'b1)
      upd_taken && upd_old != 2'b11:  upd_new = upd_old + 2'd1;
      !upd_taken && upd_old != 2'b00: upd_new = upd_old - 2'd1;
      default:                        upd_new = upd_old;
    endcase
  end

  // Table write lands after the edge, so a same-edge lookup sees the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++)
        ctr_q[i] <= 2'b01;
    end else if (upd_valid) begin
      ctr_q[upd_idx] <= upd_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
      pred_taken <= 1'b0;
    end else begin
      pred_valid <= pred_req;
      if (pred_req)
        pred_taken <= ctr_q[pred_idx][1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict       <= 1'b0;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      mispredict <= upd_valid & miss;
      if (upd_valid && branch_count != '1)
        branch_count <= branch_count + 1'b1;
      if (upd_valid && miss && mispredict_count != '1)
        mispredict_count <= mispredict_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: training, aliasing, read-before-write,
// counter and statistic saturation, asynchronous reset mid-stream.
module tb_branch_predictor;

  localparam int IB = 6;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pred_req;
  logic [31:0]   pred_pc;
  logic          pred_valid;
  logic          pred_taken;
  logic          upd_valid;
  logic [31:0]   upd_pc;
  logic          upd_taken;
  logic          upd_pred_taken;
  logic          mispredict;
  logic [SW-1:0] branch_count;
  logic [SW-1:0] mispredict_count;
`ifdef GSHARE_EN
  logic [IB-1:0] pred_ghr;
  logic [IB-1:0] upd_ghr = '0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(IB), .STAT_WIDTH(SW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .pred_req         (pred_req),
    .pred_pc          (pred_pc),
    .pred_valid       (pred_valid),
    .pred_taken       (pred_taken),
`ifdef GSHARE_EN
    .pred_ghr         (pred_ghr),
    .upd_ghr          (upd_ghr),
`endif
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_pred_taken   (upd_pred_taken),
    .mispredict       (mispredict),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pred_req  = 1'b0;
    upd_valid = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic p);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_taken      = t;
    upd_pred_taken = p;
  endtask

  task automatic look(input logic [31:0] pc);
    pred_req = 1'b1;
    pred_pc  = pc;
  endtask

  initial begin
    rst_n = 1'b0;
    pred_req = 1'b0; pred_pc = '0;
    upd_valid = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_pred_taken = 1'b0;
    #12;
    chk("rst_valid", pred_valid, 0);
    chk("rst_taken", pred_taken, 0);
    chk("rst_misp", mispredict, 0);
    chk("rst_bc", branch_count, 0);
    chk("rst_mc", mispredict_count, 0);
    rst_n = 1'b1;
    step();

    look(32'h100); step(); idle();
    chk("look0_valid", pred_valid, 1);
    chk("look0_taken", pred_taken, 0);
    chk("look0_bc", branch_count, 0);
    step();
    chk("idle_valid", pred_valid, 0);
    chk("idle_hold", pred_taken, 0);

    upd(32'h100, 1, 0); step(); idle();
    chk("upd1_misp", mispredict, 1);
    chk("upd1_bc", branch_count, 1);
    look(32'h100); step(); idle();
    chk("upd1_pulse", mispredict, 0);
    chk("ctr10_taken", pred_taken, 1);
    upd(32'h100, 1, 0); step(); idle();
    chk("upd2_misp", mispredict, 1);
    chk("upd2_bc", branch_count, 2);
    chk("upd2_mc", mispredict_count, 2);

    for (int i = 0; i < 5; i++) begin
      upd(32'h100, 1, 1); step();
    end
    idle();
    chk("sat5_misp", mispredict, 0);
    chk("sat5_bc", branch_count, 7);
    upd(32'h100, 0, 1); step(); idle();
    chk("nt_misp", mispredict, 1);
    chk("nt_mc", mispredict_count, 3);
    look(32'h100); step(); idle();
    chk("sat_then_dec", pred_taken, 1);

    upd(32'h104, 1, 1); step();
    upd(32'h104, 1, 1); step(); idle();
    look(32'h204); step(); idle();
    chk("alias_taken", pred_taken, 1);
    look(32'h108); step(); idle();
    chk("untrained", pred_taken, 0);
    chk("alias_bc", branch_count, 10);

    look(32'h100); upd(32'h100, 0, 1); step(); idle();
    chk("rbw_old", pred_taken, 1);
    chk("rbw_misp", mispredict, 1);
    look(32'h100); step(); idle();
    chk("rbw_new", pred_taken, 0);

    look(32'h104); upd(32'h108, 0, 0); step(); idle();
    chk("indep_look", pred_taken, 1);
    chk("indep_misp", mispredict, 0);
    upd(32'h108, 0, 0); step(); idle();
    look(32'h108); step(); idle();
    chk("floor00", pred_taken, 0);
    chk("indep_bc", branch_count, 13);
    chk("indep_mc", mispredict_count, 4);

    for (int i = 0; i < 12; i++) begin
      upd(32'h10c, 1, 0); step();
    end
    idle(); step();
    chk("bc_sat", branch_count, 15);
    chk("mc_sat", mispredict_count, 15);
    look(32'h10c); step(); idle();
    chk("ctr_10c", pred_taken, 1);

    look(32'h10c); upd(32'h10c, 1, 0); step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", pred_valid, 0);
    chk("arst_taken", pred_taken, 0);
    chk("arst_misp", mispredict, 0);
    chk("arst_bc", branch_count, 0);
    chk("arst_mc", mispredict_count, 0);
`ifdef GSHARE_EN
    chk("arst_ghr", pred_ghr, 0);
`endif
    idle();
    step();
    rst_n = 1'b1;
    step();
    look(32'h10c); step(); idle();
    chk("post_rst_valid", pred_valid, 1);
    chk("post_rst_taken", pred_taken, 0);
    look(32'h100); step(); idle();
    chk("post_rst_100", pred_taken, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
